// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared definitions for the traffic phase monitor: LED code
//                constants, the phase/state encoding and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // LED vector ordering is {red, yellow, green}
    localparam logic [2:0] LED_GREEN  = 3'b001;
    localparam logic [2:0] LED_YELLOW = 3'b010;
    localparam logic [2:0] LED_RED    = 3'b100;

    // Low two bits of the known phases are the externally visible phase_code.
    typedef enum logic [2:0] {
        ST_GREEN = 3'b000,
        ST_YEL_A = 3'b001,
        ST_RED   = 3'b010,
        ST_YEL_B = 3'b011,
        ST_UNK   = 3'b100
    } phase_e;

    function automatic logic is_legal_code(input logic [2:0] code);
        return (code == LED_GREEN) || (code == LED_YELLOW) || (code == LED_RED);
    endfunction

    // Where to land when the phase cannot be derived from the previous one.
    // Yellow alone is ambiguous (could be either yellow phase).
    function automatic phase_e resync_state(input logic [2:0] code);
        if (code == LED_GREEN) begin
            return ST_GREEN;
        end else if (code == LED_RED) begin
            return ST_RED;
        end
        return ST_UNK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_tick_gen
//  Description : Free-running divider. Counts 0..TICK_DIV-1 and pulses tick
//                for one clk cycle while the count sits at TICK_DIV-1.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-high reset
//                tick - one-cycle pulse every TICK_DIV cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_tick_gen #(
    parameter int TICK_DIV = 20000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == C_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_monitor
//  Description : Observes the three LED outputs of a traffic light controller,
//                recovers its phase (G -> Y -> R -> Y -> G), measures the BCD
//                dwell time per phase, counts full cycles and flags faults.
//  Ports       : clk, rst                      - clock, async active-high reset
//                redled/yellowled/greenled     - asynchronous LED levels
//                clr_err                       - clears sticky error flags
//                phase_code, phase_valid       - recovered phase
//                dwell_tens, dwell_ones        - BCD ticks in current phase
//                cycle_cnt                     - completed light cycles
//                seq_err, code_err, timeout_err- sticky fault flags
//  Options     : `define TRAFFIC_PHASE_MON_TIMEOUT_EN builds the dwell timeout
//                check; without it timeout_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_monitor
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 20000000,
    parameter int DEB_CYC   = 4,
    parameter int MAX_DWELL = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       redled,
    input  logic       yellowled,
    input  logic       greenled,
    input  logic       clr_err,
    output logic [1:0] phase_code,
    output logic       phase_valid,
    output logic [3:0] dwell_ones,
    output logic [3:0] dwell_tens,
    output logic [7:0] cycle_cnt,
    output logic       seq_err,
    output logic       code_err,
    output logic       timeout_err
);

    localparam int               DEB_W     = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0] C_DEB_MAX = DEB_W'(DEB_CYC);

    generate
        if (DEB_CYC < 1 || MAX_DWELL < 1 || MAX_DWELL > 99) begin : g_bad_params
            $error("traffic_phase_monitor: DEB_CYC must be >= 1 and MAX_DWELL in 1..99");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]       deb_last_q, deb_last_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [2:0]       acc_code_q, acc_code_d;
    logic             legal_q, legal_d;
    phase_e           state_q, state_d;
    logic [3:0]       dwell_ones_q, dwell_ones_d, dwell_tens_q, dwell_tens_d;
    logic [7:0]       cycle_cnt_q, cycle_cnt_d;
    logic             seq_err_q, seq_err_d, code_err_q, code_err_d;

    logic             w_tick;
    logic             w_accept;
    logic             w_state_chg;
    logic             w_seq_evt, w_code_evt, w_cyc_evt;
    logic [2:0]       w_state_bits;

    traffic_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // ------------------------------------------------------------------
    // Synchronizer and debounce
    // deb_cnt counts the current run of identical samples, saturating at
    // DEB_CYC. A code is accepted once, on the cycle its run reaches DEB_CYC,
    // and only if it differs from the code already accepted; short glitches
    // that return to the accepted code therefore generate no event.
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d    = {redled, yellowled, greenled};
        sync2_d    = sync1_q;
        deb_last_d = sync2_q;
        if (sync2_q != deb_last_q) begin
            deb_cnt_d = DEB_W'(1);
        end else if (deb_cnt_q == C_DEB_MAX) begin
            deb_cnt_d = C_DEB_MAX;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
        w_accept   = (deb_cnt_d == C_DEB_MAX) && (sync2_q != acc_code_q);
        acc_code_d = w_accept ? sync2_q : acc_code_q;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNK;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Re-accepting the code of the current phase (e.g.
    // after an illegal code) is not a transition and raises nothing.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        legal_d    = legal_q;
        w_seq_evt  = 1'b0;
        w_code_evt = 1'b0;
        w_cyc_evt  = 1'b0;
        if (w_accept) begin
            if (!is_legal_code(sync2_q)) begin
                w_code_evt = 1'b1;
                legal_d    = 1'b0;
            end else begin
                legal_d = 1'b1;
                case (state_q)
                    ST_GREEN: begin
                        if (sync2_q == LED_YELLOW) begin
                            state_d = ST_YEL_A;
                        end else if (sync2_q != LED_GREEN) begin
                            w_seq_evt = 1'b1;
                            state_d   = resync_state(sync2_q);
                        end
                    end
                    ST_YEL_A: begin
                        if (sync2_q == LED_RED) begin
                            state_d = ST_RED;
                        end else if (sync2_q != LED_YELLOW) begin
                            w_seq_evt = 1'b1;
                            state_d   = resync_state(sync2_q);
                        end
                    end
                    ST_RED: begin
                        if (sync2_q == LED_YELLOW) begin
                            state_d = ST_YEL_B;
                        end else if (sync2_q != LED_RED) begin
                            w_seq_evt = 1'b1;
                            state_d   = resync_state(sync2_q);
                        end
                    end
                    ST_YEL_B: begin
                        if (sync2_q == LED_GREEN) begin
                            state_d   = ST_GREEN;
                            w_cyc_evt = 1'b1;
                        end else if (sync2_q != LED_YELLOW) begin
                            w_seq_evt = 1'b1;
                            state_d   = resync_state(sync2_q);
                        end
                    end
                    default: begin
                        state_d = resync_state(sync2_q);
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_bits = state_q;
        phase_code   = (state_q == ST_UNK) ? 2'd0 : w_state_bits[1:0];
        phase_valid  = (state_q != ST_UNK) && legal_q;
    end

    // ------------------------------------------------------------------
    // Dwell, cycle counter and sticky flags
    // A state change wins over a coincident tick so dwell restarts at 00.
    // ------------------------------------------------------------------
    assign w_state_chg = (state_d != state_q);

    always_comb begin
        dwell_ones_d = dwell_ones_q;
        dwell_tens_d = dwell_tens_q;
        if (w_state_chg) begin
            dwell_ones_d = 4'd0;
            dwell_tens_d = 4'd0;
        end else if (w_tick && !(dwell_ones_q == 4'd9 && dwell_tens_q == 4'd9)) begin
            if (dwell_ones_q == 4'd9) begin
                dwell_ones_d = 4'd0;
                dwell_tens_d = dwell_tens_q + 4'd1;
            end else begin
                dwell_ones_d = dwell_ones_q + 4'd1;
            end
        end
        cycle_cnt_d = cycle_cnt_q + (w_cyc_evt ? 8'd1 : 8'd0);
        seq_err_d   = w_seq_evt  | (seq_err_q  & ~clr_err);
        code_err_d  = w_code_evt | (code_err_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_last_q   <= '0;
            deb_cnt_q    <= '0;
            acc_code_q   <= '0;
            legal_q      <= 1'b0;
            dwell_ones_q <= '0;
            dwell_tens_q <= '0;
            cycle_cnt_q  <= '0;
            seq_err_q    <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_last_q   <= deb_last_d;
            deb_cnt_q    <= deb_cnt_d;
            acc_code_q   <= acc_code_d;
            legal_q      <= legal_d;
            dwell_ones_q <= dwell_ones_d;
            dwell_tens_q <= dwell_tens_d;
            cycle_cnt_q  <= cycle_cnt_d;
            seq_err_q    <= seq_err_d;
            code_err_q   <= code_err_d;
        end
    end

    assign dwell_ones = dwell_ones_q;
    assign dwell_tens = dwell_tens_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign seq_err    = seq_err_q;
    assign code_err   = code_err_q;

    // ------------------------------------------------------------------
    // Optional dwell timeout: flags a tick that would push dwell past
    // MAX_DWELL in a known phase.
    // ------------------------------------------------------------------
`ifdef TRAFFIC_PHASE_MON_TIMEOUT_EN
    logic [6:0] w_dwell_bin;
    logic       timeout_err_q, timeout_err_d;

    always_comb begin
        w_dwell_bin   = 7'(dwell_tens_q) * 7'd10 + 7'(dwell_ones_q);
        timeout_err_d = (w_tick && (state_q != ST_UNK) && !w_state_chg &&
                         (32'(w_dwell_bin) >= 32'(MAX_DWELL)))
                        | (timeout_err_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire
